mdma_ram_ecc_ctrl: RTL and testbench
====================================

# mdma_ram_ecc_ctrl

Parametrised SECDED-protected single-port-write/single-port-read RAM controller for MDMA context and descriptor storage; generalises the fixed 80-bit × 256 RAM interface to arbitrary width and depth. Encodes write data, stores data plus check bits in an inferred memory, and corrects single-bit / flags double-bit errors on read through a configurable read pipeline. Provides write-to-read bypass, saturating error counters and first-error address capture for the MDMA error-status registers.

## Interface
- DATA_W, 80, data width in bits (8..256)
- DEPTH, 256, number of entries (power of two, ≥ 2)
- ADR_W, $clog2(DEPTH), address width (derived; not overridden)
- RD_PIPE, 1, extra output register stage after decode (0 or 1)
- CNT_W, 16, error counter width
- clk  input  1  clock
- rst  input  1  reset: one clock; reset is asynchronous and active-high
- wen  input  1  write enable
- wadr  input  ADR_W  write address
- wdat  input  DATA_W  write data
- ren  input  1  read enable
- radr  input  ADR_W  read address
- rdat  output  DATA_W  corrected read data
- rvld  output  1  rdat/rsbe/rdbe valid strobe
- rsbe  output  1  single-bit error detected and corrected (qualified by rvld)
- rdbe  output  1  double-bit error detected, uncorrectable (qualified by rvld)
- err_clr  input  1  clears counters and capture register
- sbe_cnt  output  CNT_W  saturating single-bit error count
- dbe_cnt  output  CNT_W  saturating double-bit error count
- err_adr  output  ADR_W  address of first error since last clear
- err_adr_vld  output  1  err_adr holds a captured address
- inj_sbe  input  1  flip codeword bit 0 on the next write
- inj_dbe  input  1  flip codeword bits 0 and 1 on the next write

## Operation
- ECC_W = p+1, p smallest with 2^p ≥ DATA_W+p+1 (DATA_W=80 → ECC_W=8). Hamming code plus overall parity; stored word DATA_W+ECC_W bits.
- Memory contents are not reset; reading an unwritten location yields undefined data/flags (bench must initialise).
- Read: ren samples radr; memory read registered; decode combinational after memory register; optional output register per RD_PIPE.
- Syndrome 0, parity ok → clean. Syndrome ≠0, parity bad → flip indicated bit, rsbe=1 (error in check bits also rsbe, data unchanged). Syndrome ≠0, parity ok → rdbe=1, rdat = raw stored data. Syndrome 0, parity bad → rsbe=1 (parity bit error).
- Collision: wen && ren && wadr==radr in same cycle → read returns the new wdat (write-first bypass), rsbe=rdbe=0, injection ignored for bypassed read only.
- Counters: increment by 1 on each rvld with rsbe / rdbe; saturate at all-ones.
- err_adr: captured from the read address of the first rvld with rsbe|rdbe while err_adr_vld=0; err_adr_vld set. Later errors do not overwrite.
- err_clr: counters → 0, err_adr_vld → 0. Clear and error in same cycle: clear wins, then that error counts (count=1) and is captured.
- Injection: inj_sbe/inj_dbe sampled with wen; apply only to that write. Both high → dbe pattern. Asserted without wen → ignored (not held pending).

## Timing
- Read latency ren → rvld: 1+RD_PIPE cycles (RD_PIPE=1: ren at N, rvld at N+2). Full throughput, one read per cycle back-to-back.
- Write committed at the clock edge with wen; read of that address issued next cycle returns new data.
- Reset values: rdat=0, rvld=0, rsbe=0, rdbe=0, sbe_cnt=0, dbe_cnt=0, err_adr=0, err_adr_vld=0. Reset mid-read: in-flight reads discarded, no rvld after reset deassertion; memory contents preserved.
- rsbe/rdbe forced 0 whenever rvld=0.

## Configuration
- MDMA_RAM_ECC_INJ_EN defined: inj_sbe/inj_dbe active as above.
- Not defined: inj_sbe/inj_dbe ports present but ignored; no injection logic synthesised.

## Test plan
- Write 0x1234_5678_9ABC_DEF0_1122 to adr 5, read adr 5 (RD_PIPE=1) → rvld at +2, rdat matches, rsbe=rdbe=0, counters 0.
- With MDMA_RAM_ECC_INJ_EN: write adr 10 with inj_sbe, read twice → rdat correct, rsbe=1 both reads, sbe_cnt=2, err_adr=10, err_adr_vld=1.
- Write adr 20 with inj_dbe, read → rdbe=1, rsbe=0, dbe_cnt=1; err_adr stays 10 if not cleared; after err_clr, read again → err_adr=20.
- Same-cycle write 0xAA.. and read adr 255 (old 0x55..) → rdat=0xAA.., no error flags.
- Force sbe_cnt to saturation (CNT_W=4, 16 injected reads) → sbe_cnt holds 15; err_clr coincident with an error → sbe_cnt=1.
- Assert rst with two reads in flight → no rvld after release; subsequent read of previously written data returns it intact.

Source files
------------

// File: rtl/mdma_ram_ecc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdma_ram_ecc_ctrl
// Function : SECDED-protected RAM with registered read, write-first bypass,
//            saturating error counters and first-error address capture.
//            Optional error injection enabled by MDMA_RAM_ECC_INJ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mdma_ram_ecc_ctrl #(
    parameter int DATA_W  = 80,
    parameter int DEPTH   = 256,
    parameter int ADR_W   = $clog2(DEPTH),
    parameter int RD_PIPE = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADR_W-1:0]  wadr,
    input  logic [DATA_W-1:0] wdat,
    input  logic              ren,
    input  logic [ADR_W-1:0]  radr,
    output logic [DATA_W-1:0] rdat,
    output logic              rvld,
    output logic              rsbe,
    output logic              rdbe,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  sbe_cnt,
    output logic [CNT_W-1:0]  dbe_cnt,
    output logic [ADR_W-1:0]  err_adr,
    output logic              err_adr_vld,
    input  logic              inj_sbe,
    input  logic              inj_dbe
);

    function automatic int calc_p(input int dw);
        int p;
        p = 0;
        for (int q = 1; q < 12; q++) begin
            if (p == 0 && (1 << q) >= dw + q + 1) p = q;
        end
        return p;
    endfunction

    localparam int P     = calc_p(DATA_W);
    localparam int ECC_W = P + 1;
    localparam int CW_W  = DATA_W + ECC_W;
    localparam int NPOS  = DATA_W + P;

    // Hamming position of data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int pos = 3; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (n == idx) r = pos;
                n++;
            end
        end
        return r;
    endfunction

    function automatic logic [P-1:0] hamming_chk(input logic [DATA_W-1:0] d);
        logic [P-1:0] c;
        int           pos;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pos = data_pos(i);
            for (int j = 0; j < P; j++) begin
                if (((pos >> j) & 1) != 0) c[j] = c[j] ^ d[i];
            end
        end
        return c;
    endfunction

    // Stored word layout: {overall parity, hamming check bits, data}.
    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [P-1:0] c;
        c = hamming_chk(d);
        return {^{c, d}, c, d};
    endfunction

    logic [CW_W-1:0]   mem_q [DEPTH];
    logic [1:0]        w_inj;
    logic [CW_W-1:0]   w_byp_word;
    logic [CW_W-1:0]   w_wr_word;

`ifdef MDMA_RAM_ECC_INJ_EN
    assign w_inj = inj_dbe ? 2'b11 : (inj_sbe ? 2'b01 : 2'b00);
`else
    logic w_unused_inj;
    assign w_unused_inj = inj_sbe ^ inj_dbe;
    assign w_inj        = 2'b00;
`endif

    assign w_byp_word = encode(wdat);
    assign w_wr_word  = w_byp_word ^ {{(CW_W-2){1'b0}}, w_inj};

    always_ff @(posedge clk) begin
        if (wen) mem_q[wadr] <= w_wr_word;
    end

    // Read stage: registered memory word, address and valid.
    logic              rd_vld_q, rd_vld_d;
    logic [ADR_W-1:0]  rd_adr_q, rd_adr_d;
    logic [CW_W-1:0]   rd_word_q, rd_word_d;

    always_comb begin
        rd_vld_d  = ren;
        rd_adr_d  = rd_adr_q;
        rd_word_d = rd_word_q;
        if (ren) begin
            rd_adr_d  = radr;
            rd_word_d = (wen && (wadr == radr)) ? w_byp_word : mem_q[radr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_adr_q  <= '0;
            rd_word_q <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_adr_q  <= rd_adr_d;
            rd_word_q <= rd_word_d;
        end
    end

    // Decode. A bad overall parity means an odd error count: correct it.
    logic [P-1:0]      w_syn;
    logic              w_par_bad;
    logic [DATA_W-1:0] w_dec_dat;
    logic              w_dec_sbe;
    logic              w_dec_dbe;

    always_comb begin
        w_syn     = rd_word_q[DATA_W +: P] ^ hamming_chk(rd_word_q[DATA_W-1:0]);
        w_par_bad = ^rd_word_q;
        w_dec_dat = rd_word_q[DATA_W-1:0];
        if (w_par_bad) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (w_syn == P'(data_pos(i))) w_dec_dat[i] = ~w_dec_dat[i];
            end
        end
        w_dec_sbe = rd_vld_q & w_par_bad;
        w_dec_dbe = rd_vld_q & (|w_syn) & ~w_par_bad;
    end

    logic              w_o_vld;
    logic              w_o_sbe;
    logic              w_o_dbe;
    logic [DATA_W-1:0] w_o_dat;
    logic [ADR_W-1:0]  w_o_adr;

    if (RD_PIPE != 0) begin : g_out_reg
        logic              out_vld_q;
        logic              out_sbe_q;
        logic              out_dbe_q;
        logic [DATA_W-1:0] out_dat_q;
        logic [ADR_W-1:0]  out_adr_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_vld_q <= 1'b0;
                out_sbe_q <= 1'b0;
                out_dbe_q <= 1'b0;
                out_dat_q <= '0;
                out_adr_q <= '0;
            end else begin
                out_vld_q <= rd_vld_q;
                out_sbe_q <= w_dec_sbe;
                out_dbe_q <= w_dec_dbe;
                out_dat_q <= w_dec_dat;
                out_adr_q <= rd_adr_q;
            end
        end

        assign w_o_vld = out_vld_q;
        assign w_o_sbe = out_sbe_q;
        assign w_o_dbe = out_dbe_q;
        assign w_o_dat = out_dat_q;
        assign w_o_adr = out_adr_q;
    end else begin : g_out_comb
        assign w_o_vld = rd_vld_q;
        assign w_o_sbe = w_dec_sbe;
        assign w_o_dbe = w_dec_dbe;
        assign w_o_dat = w_dec_dat;
        assign w_o_adr = rd_adr_q;
    end

    assign rvld = w_o_vld;
    assign rdat = w_o_dat;
    assign rsbe = w_o_vld & w_o_sbe;
    assign rdbe = w_o_vld & w_o_dbe;

    // Error bookkeeping: a clear applies first, then the current error counts.
    logic [CNT_W-1:0] sbe_cnt_q, sbe_cnt_d;
    logic [CNT_W-1:0] dbe_cnt_q, dbe_cnt_d;
    logic [ADR_W-1:0] err_adr_q, err_adr_d;
    logic             err_vld_q, err_vld_d;

    always_comb begin
        sbe_cnt_d = err_clr ? '0 : sbe_cnt_q;
        dbe_cnt_d = err_clr ? '0 : dbe_cnt_q;
        err_vld_d = err_clr ? 1'b0 : err_vld_q;
        err_adr_d = err_adr_q;
        if (rsbe && (sbe_cnt_d != '1)) sbe_cnt_d = sbe_cnt_d + 1'b1;
        if (rdbe && (dbe_cnt_d != '1)) dbe_cnt_d = dbe_cnt_d + 1'b1;
        if ((rsbe || rdbe) && !err_vld_d) begin
            err_vld_d = 1'b1;
            err_adr_d = w_o_adr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
            err_adr_q <= '0;
            err_vld_q <= 1'b0;
        end else begin
            sbe_cnt_q <= sbe_cnt_d;
            dbe_cnt_q <= dbe_cnt_d;
            err_adr_q <= err_adr_d;
            err_vld_q <= err_vld_d;
        end
    end

    assign sbe_cnt     = sbe_cnt_q;
    assign dbe_cnt     = dbe_cnt_q;
    assign err_adr     = err_adr_q;
    assign err_adr_vld = err_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_mdma_ram_ecc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdma_ram_ecc_ctrl
// Function : Randomized self-checking bench with a behavioural memory/error
//            model. Injection expectations follow MDMA_RAM_ECC_INJ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdma_ram_ecc_ctrl;

    localparam int DW    = 80;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic          clk;
    logic          rst;
    logic          wen;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdat;
    logic          ren;
    logic [AW-1:0] radr;
    logic [DW-1:0] rdat;
    logic          rvld;
    logic          rsbe;
    logic          rdbe;
    logic          err_clr;
    logic [CW-1:0] sbe_cnt;
    logic [CW-1:0] dbe_cnt;
    logic [AW-1:0] err_adr;
    logic          err_adr_vld;
    logic          inj_sbe;
    logic          inj_dbe;

    mdma_ram_ecc_ctrl #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .RD_PIPE(1),
        .CNT_W  (CW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .wadr       (wadr),
        .wdat       (wdat),
        .ren        (ren),
        .radr       (radr),
        .rdat       (rdat),
        .rvld       (rvld),
        .rsbe       (rsbe),
        .rdbe       (rdbe),
        .err_clr    (err_clr),
        .sbe_cnt    (sbe_cnt),
        .dbe_cnt    (dbe_cnt),
        .err_adr    (err_adr),
        .err_adr_vld(err_adr_vld),
        .inj_sbe    (inj_sbe),
        .inj_dbe    (inj_dbe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: logical contents plus number of bits flipped at write.
    typedef struct {
        int            due;
        logic [DW-1:0] dat;
        logic          sbe;
        logic          dbe;
        logic [AW-1:0] adr;
    } exp_t;

    logic [DW-1:0] m_dat [DEPTH];
    int            m_err [DEPTH];
    exp_t          q[$];
    int            m_sbe;
    int            m_dbe;
    logic [AW-1:0] m_eadr;
    logic          m_evld;

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic r, input logic [AW-1:0] ra,
                        input logic is, input logic id, input logic clr);
        exp_t          e;
        logic          ev_s;
        logic          ev_d;
        logic [AW-1:0] ev_a;
        int            ie;
        logic [DW-1:0] two_bits;
        two_bits = '0;
        two_bits[1:0] = 2'b11;
        @(negedge clk);
        cyc++;
        chk("sbe_cnt", 128'(sbe_cnt), 128'(m_sbe));
        chk("dbe_cnt", 128'(dbe_cnt), 128'(m_dbe));
        chk("err_adr_vld", 128'(err_adr_vld), 128'(m_evld));
        if (m_evld) chk("err_adr", 128'(err_adr), 128'(m_eadr));
        ev_s = 1'b0;
        ev_d = 1'b0;
        ev_a = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rvld", 128'(rvld), 128'(1));
            chk("rdat", 128'(rdat), 128'(e.dat));
            chk("rsbe", 128'(rsbe), 128'(e.sbe));
            chk("rdbe", 128'(rdbe), 128'(e.dbe));
            ev_s = e.sbe;
            ev_d = e.dbe;
            ev_a = e.adr;
        end else begin
            chk("rvld_idle", 128'(rvld), 128'(0));
            chk("flags_idle", 128'({rsbe, rdbe}), 128'(0));
        end
        if (clr) begin
            m_sbe  = 0;
            m_dbe  = 0;
            m_evld = 1'b0;
        end
        if (ev_s && m_sbe < CMAX) m_sbe++;
        if (ev_d && m_dbe < CMAX) m_dbe++;
        if ((ev_s || ev_d) && !m_evld) begin
            m_evld = 1'b1;
            m_eadr = ev_a;
        end
        wen = w; wadr = wa; wdat = wd; ren = r; radr = ra;
        inj_sbe = is; inj_dbe = id; err_clr = clr;
        if (r) begin
            e.due = cyc + 2;
            e.adr = ra;
            if (w && wa == ra) begin
                e.dat = wd;
                e.sbe = 1'b0;
                e.dbe = 1'b0;
            end else begin
                ie    = m_err[ra];
                e.dat = (ie == 2) ? (m_dat[ra] ^ two_bits) : m_dat[ra];
                e.sbe = (ie == 1);
                e.dbe = (ie == 2);
            end
            q.push_back(e);
        end
        if (w) begin
            m_dat[wa] = wd;
            ie = 0;
`ifdef MDMA_RAM_ECC_INJ_EN
            if (id) ie = 2;
            else if (is) ie = 1;
`endif
            m_err[wa] = ie;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        wen = 1'b0; ren = 1'b0; err_clr = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
        q.delete();
        m_sbe = 0; m_dbe = 0; m_evld = 1'b0; m_eadr = '0;
        @(negedge clk);
        cyc++;
        chk("rst_rvld", 128'(rvld), 128'(0));
        chk("rst_rdat", 128'(rdat), 128'(0));
        chk("rst_flags", 128'({rsbe, rdbe}), 128'(0));
        chk("rst_cnts", 128'({sbe_cnt, dbe_cnt}), 128'(0));
        chk("rst_err_adr", 128'({err_adr_vld, err_adr}), 128'(0));
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        rst = 1'b1; wen = 1'b0; wadr = '0; wdat = '0; ren = 1'b0; radr = '0;
        err_clr = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
        m_sbe = 0; m_dbe = 0; m_evld = 1'b0; m_eadr = '0;
        for (int i = 0; i < DEPTH; i++) m_err[i] = 0;
        do_reset();

        for (int i = 0; i < DEPTH; i++)
            step(1'b1, AW'(i), rnd_data(), 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Basic write then read, and write-first collision.
        step(1'b1, 8'd5, 80'h1234_5678_9ABC_DEF0_1122, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd255, {10{8'h55}}, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd255, {10{8'hAA}}, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Injection sequences (flags expected only when injection is built in).
        step(1'b1, 8'd10, rnd_data(), 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd20, rnd_data(), 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'd20, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 8'd20, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'd30, 1'b0, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 16; i++) step(1'b0, '0, '0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, '0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Randomized mixed traffic over a small window to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), a, rnd_data(),
                 1'($urandom_range(0, 1)), b,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 39) == 0);
        end
        idle(3);

        // Reset with reads in flight; contents must survive.
        step(1'b0, '0, '0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        do_reset();
        idle(4);
        step(1'b0, '0, '0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
